exc_commit: RTL
===============

EXC_COMMIT -- requirements
Module: exc_commit

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 2: cycles of wrong-path discard after a flush (legal 1..7).
REQ-002 SHALL have parameter INT_ECODE, default 6'h00: ecode reported for an interrupt.
REQ-003 SHALL have ports: clk input 1, the single clock; reset input 1, synchronous active-high reset.
REQ-004 SHALL have input ms_valid 1 (MEM-stage instruction offered) and output ws_allowin 1 (WB accepts this cycle).
REQ-005 SHALL have inputs ms_pc 32, ms_ex 1, ms_ecode 6, ms_esubcode 9, ms_ertn 1: pc, pending exception, ecode, esubcode, ertn flag.
REQ-006 SHALL have inputs ms_csr_re 1, ms_csr_we 1, ms_csr_num 14, ms_csr_wmask 32, ms_csr_wvalue 32: CSR access fields.
REQ-007 SHALL have inputs ms_rf_we 1, ms_rf_waddr 5, ms_rf_wdata 32: GPR writeback fields.
REQ-008 SHALL have inputs has_int 1, ex_entry 32, ertn_entry 32, csr_rvalue 32, from the CSR file.
REQ-009 SHALL have outputs csr_re 1, csr_we 1, csr_num 14, csr_wmask 32, csr_wvalue 32: CSR file port.
REQ-010 SHALL have outputs wb_ex 1, wb_pc 32, wb_ecode 6, wb_esubcode 9, ertn_flush 1: CSR hardware interface.
REQ-011 SHALL have outputs rf_we 1, rf_waddr 5, rf_wdata 32: register file write.
REQ-012 SHALL have outputs flush 1, flush_target 32, debug_wb_pc 32: front-end redirect and trace pc.

Function
REQ-013 SHALL hold one instruction in a WB register, loaded when ms_valid && ws_allowin; ws_valid cleared otherwise.
REQ-014 SHALL drive ws_allowin = 1 in state RUN and 0 in state DRAIN.
REQ-015 SHALL commit the held instruction in the cycle after capture (latency 1); all commit outputs combinational from the WB register and gated by ws_valid.
REQ-016 SHALL raise a commit exception when ws_valid && (held ex || int_taken); int_taken = ws_valid && has_int && !held ex.
REQ-017 On exception: wb_ex=1; wb_ecode/wb_esubcode = held values, or INT_ECODE/0 when int_taken; wb_pc=held pc; rf_we=0; csr_we=0; ertn_flush=0.
REQ-018 ertn_flush SHALL equal ws_valid && held ertn && !exception; exception wins over ertn on the same instruction.
REQ-019 Without exception: csr_we/csr_re/num/wmask/wvalue pass through from the held fields; rf_we = held rf_we.
REQ-020 rf_wdata SHALL be csr_rvalue when held csr_re, otherwise held rf_wdata.
REQ-021 flush SHALL equal wb_ex || ertn_flush; flush_target = ex_entry on wb_ex, ertn_entry on ertn_flush, else 0.
REQ-022 FSM states RUN, DRAIN. RUN->DRAIN when flush; 3-bit counter loaded with DRAIN_CYCLES-1; DRAIN decrements; DRAIN->RUN when counter is 0.
REQ-023 In DRAIN, ms_valid SHALL be ignored and no instruction captured.
REQ-024 A flush cycle SHALL not capture the incoming instruction (ws_allowin stays 1 but the capture is suppressed); ws_valid is 0 in the next cycle.
REQ-025 debug_wb_pc SHALL equal held pc when ws_valid, else 0.

Reset
REQ-026 On reset: state RUN, counter 0, ws_valid 0; every output 0 except ws_allowin=1.
REQ-027 Reset during DRAIN SHALL return to RUN on the next edge, discarding the count.

Configuration
REQ-028 Macro EXC_COMMIT_INT_EN: when defined, has_int is sampled per REQ-016. When undefined, int_taken is constant 0, has_int is unused, and interrupts never commit.

Verification
REQ-029 Normal: ms_valid, pc 0x1c000100, rf_we, waddr 5, wdata 0x1234 -> next cycle rf_we=1, waddr=5, wdata=0x1234, debug_wb_pc=0x1c000100, flush=0.
REQ-030 CSR read: csr_re, num 0x5, csr_rvalue 0xABCD -> rf_wdata=0xABCD, csr_re=1, csr_num=0x5.
REQ-031 Exception: ms_ex, ecode 0xB, csr_we set, ex_entry 0x1c008000 -> wb_ex=1, ecode 0xB, csr_we=0, rf_we=0, flush_target 0x1c008000; ws_allowin=0 for the next 2 cycles; ms_valid offered in that window is dropped.
REQ-032 Ertn: ms_ertn, ertn_entry 0x1c000200 -> ertn_flush=1, wb_ex=0, flush_target 0x1c000200.
REQ-033 Interrupt with EXC_COMMIT_INT_EN defined: has_int=1 on an ordinary add -> wb_ex=1, ecode 0x00, rf_we=0. With the macro undefined -> add commits normally.
REQ-034 Reset asserted in the first DRAIN cycle -> next cycle ws_allowin=1, all outputs 0.

Source files
------------

// File: rtl/exc_commit.sv
// exc_commit -- write-back stage exception/ertn commit with front-end flush.
//
// Holds one MEM-stage instruction in a WB register and commits it one cycle
// after capture. A pending exception, an interrupt, or an ertn redirects the
// front end. The stage then spends DRAIN_CYCLES cycles refusing input while
// wrong-path instructions drain.
//
// Parameters : DRAIN_CYCLES (1..7), INT_ECODE (ecode reported for interrupts)
// Config     : EXC_COMMIT_INT_EN -- when defined, has_int can raise an
//              interrupt on the committing instruction. When undefined,
//              interrupts never commit and has_int is ignored.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   ms_valid / ws_allowin            MEM->WB handshake
//   ms_pc, ms_ex, ms_ecode, ms_esubcode, ms_ertn      instruction status
//   ms_csr_re/we/num/wmask/wvalue    CSR access fields
//   ms_rf_we/waddr/wdata             GPR writeback fields
//   has_int, ex_entry, ertn_entry, csr_rvalue         from the CSR file
//   csr_re/we/num/wmask/wvalue       CSR file access port
//   wb_ex, wb_pc, wb_ecode, wb_esubcode, ertn_flush   CSR hardware interface
//   rf_we, rf_waddr, rf_wdata        register file write
//   flush, flush_target, debug_wb_pc front-end redirect and trace pc
module exc_commit #(
  parameter int          DRAIN_CYCLES = 2,
  parameter logic [5:0]  INT_ECODE    = 6'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ms_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic        ms_ex,
  input  logic [5:0]  ms_ecode,
  input  logic [8:0]  ms_esubcode,
  input  logic        ms_ertn,
  input  logic        ms_csr_re,
  input  logic        ms_csr_we,
  input  logic [13:0] ms_csr_num,
  input  logic [31:0] ms_csr_wmask,
  input  logic [31:0] ms_csr_wvalue,
  input  logic        ms_rf_we,
  input  logic [4:0]  ms_rf_waddr,
  input  logic [31:0] ms_rf_wdata,
  input  logic        has_int,
  input  logic [31:0] ex_entry,
  input  logic [31:0] ertn_entry,
  input  logic [31:0] csr_rvalue,
  output logic        csr_re,
  output logic        csr_we,
  output logic [13:0] csr_num,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  output logic        wb_ex,
  output logic [31:0] wb_pc,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic        ertn_flush,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        flush,
  output logic [31:0] flush_target,
  output logic [31:0] debug_wb_pc
);

  typedef enum logic {S_RUN, S_DRAIN} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic        ertn;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } ws_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       ws_valid_q, ws_valid_d;
  ws_t        ws_q, ws_d;

  logic int_taken;
  logic exc;
  logic capture;

`ifdef EXC_COMMIT_INT_EN
  assign int_taken = ws_valid_q && has_int && !ws_q.ex;
`else
  logic unused_has_int;
  assign unused_has_int = has_int;
  assign int_taken      = 1'b0;
`endif

  assign exc        = ws_valid_q && (ws_q.ex || int_taken);
  assign ws_allowin = (state_q == S_RUN);
  // The instruction arriving alongside a flush is on the wrong path.
  assign capture    = ms_valid && ws_allowin && !flush;

  // Commit outputs: purely combinational from the WB register.
  always_comb begin
    wb_ex        = exc;
    wb_pc        = ws_valid_q ? ws_q.pc : 32'h0;
    wb_ecode     = 6'h0;
    wb_esubcode  = 9'h0;
    if (exc) begin
      wb_ecode    = int_taken ? INT_ECODE : ws_q.ecode;
      wb_esubcode = int_taken ? 9'h0      : ws_q.esubcode;
    end
    ertn_flush   = ws_valid_q && ws_q.ertn && !exc;
    csr_re       = ws_valid_q && ws_q.csr_re && !exc;
    csr_we       = ws_valid_q && ws_q.csr_we && !exc;
    csr_num      = ws_valid_q ? ws_q.csr_num    : 14'h0;
    csr_wmask    = ws_valid_q ? ws_q.csr_wmask  : 32'h0;
    csr_wvalue   = ws_valid_q ? ws_q.csr_wvalue : 32'h0;
    rf_we        = ws_valid_q && ws_q.rf_we && !exc;
    rf_waddr     = ws_valid_q ? ws_q.rf_waddr : 5'h0;
    rf_wdata     = 32'h0;
    if (ws_valid_q) rf_wdata = ws_q.csr_re ? csr_rvalue : ws_q.rf_wdata;
    flush        = exc || ertn_flush;
    flush_target = exc ? ex_entry : (ertn_flush ? ertn_entry : 32'h0);
    debug_wb_pc  = ws_valid_q ? ws_q.pc : 32'h0;
  end

  // Next-state: FSM, drain counter, WB register.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ws_valid_d = capture;
    ws_d       = ws_q;
    if (capture) begin
      ws_d.pc         = ms_pc;
      ws_d.ex         = ms_ex;
      ws_d.ecode      = ms_ecode;
      ws_d.esubcode   = ms_esubcode;
      ws_d.ertn       = ms_ertn;
      ws_d.csr_re     = ms_csr_re;
      ws_d.csr_we     = ms_csr_we;
      ws_d.csr_num    = ms_csr_num;
      ws_d.csr_wmask  = ms_csr_wmask;
      ws_d.csr_wvalue = ms_csr_wvalue;
      ws_d.rf_we      = ms_rf_we;
      ws_d.rf_waddr   = ms_rf_waddr;
      ws_d.rf_wdata   = ms_rf_wdata;
    end
    case (state_q)
      S_RUN: begin
        if (flush) begin
          state_d = S_DRAIN;
          cnt_d   = 3'(DRAIN_CYCLES - 1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == 3'd0) state_d = S_RUN;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RUN;
      cnt_q      <= 3'd0;
      ws_valid_q <= 1'b0;
      ws_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ws_valid_q <= ws_valid_d;
      ws_q       <= ws_d;
    end
  end

endmodule
